// File: rtl/shell_engine_pkg.sv
// Shared types and constants for the tank shell engine.
package shell_engine_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CNT_W   = 5;

  localparam int unsigned SHELL_SPEED     = 4;
  localparam int unsigned COOLDOWN_FRAMES = 30;
  localparam int unsigned TANK_HALF       = 16;
  localparam int unsigned SHELL_HALF      = 2;
  localparam int unsigned SCREEN_MAX_X    = 639;
  localparam int unsigned SCORE_MAX       = 9;

  localparam logic [7:0] KEY_FIRE_ONE = 8'h2C;
  localparam logic [7:0] KEY_FIRE_TWO = 8'h28;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } shell_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  // Distance on one axis, widened by a bit so it never wraps.
  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W:0] a,
                                                input logic [COORD_W:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/shell_engine_if.sv
// Bus between the game logic (tank positions, keyboard, vsync) and the shell engine.
interface shell_engine_if;
  import shell_engine_pkg::*;

  logic                 VS;
  logic [7:0]           keycode;
  logic [COORD_W-1:0]   TankOneX;
  logic [COORD_W-1:0]   TankOneY;
  logic [COORD_W-1:0]   TankTwoX;
  logic [COORD_W-1:0]   TankTwoY;
  logic [COORD_W-1:0]   ShellOneX;
  logic [COORD_W-1:0]   ShellOneY;
  logic                 ShellOneActive;
  logic [COORD_W-1:0]   ShellTwoX;
  logic [COORD_W-1:0]   ShellTwoY;
  logic                 ShellTwoActive;
  logic                 HitOne;
  logic                 HitTwo;
  logic [SCORE_W-1:0]   ScoreOne;
  logic [SCORE_W-1:0]   ScoreTwo;

  modport master (
    output VS, keycode, TankOneX, TankOneY, TankTwoX, TankTwoY,
    input  ShellOneX, ShellOneY, ShellOneActive,
    input  ShellTwoX, ShellTwoY, ShellTwoActive,
    input  HitOne, HitTwo, ScoreOne, ScoreTwo
  );

  modport slave (
    input  VS, keycode, TankOneX, TankOneY, TankTwoX, TankTwoY,
    output ShellOneX, ShellOneY, ShellOneActive,
    output ShellTwoX, ShellTwoY, ShellTwoActive,
    output HitOne, HitTwo, ScoreOne, ScoreTwo
  );
endinterface

// File: rtl/shell_engine_shell_unit.sv
// One player's shell: launch, per-frame flight, hit test against the opposing tank,
// cooldown and saturating score. DIR > 0 flies toward +X, otherwise toward -X.
module shell_unit
  import shell_engine_pkg::*;
#(
  parameter int         DIR      = 1,
  parameter logic [7:0] FIRE_KEY = KEY_FIRE_ONE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [7:0]         keycode,
  input  point_t             own_tank,
  input  point_t             opp_tank,
  output point_t             shell_pos,
  output logic               active,
  output logic               hit,
  output logic [SCORE_W-1:0] score
);

  localparam logic [COORD_W:0] HIT_RANGE = (COORD_W+1)'(TANK_HALF + SHELL_HALF);

  shell_state_t         state;
  logic [CNT_W-1:0]     cool_cnt;
  logic                 armed;

  logic                 fire_key_c;
  logic [COORD_W:0]     moved_x_c;
  logic [COORD_W-1:0]   spawn_x_c;
  logic                 off_screen_c;
  logic                 strike_c;

  // Next position, spawn point and the hit/off-screen decisions for this frame.
  always_comb begin
    fire_key_c = (keycode == FIRE_KEY);
    if (DIR > 0) begin
      moved_x_c    = {1'b0, shell_pos.x} + (COORD_W+1)'(SHELL_SPEED);
      spawn_x_c    = own_tank.x + COORD_W'(TANK_HALF);
      off_screen_c = (moved_x_c > (COORD_W+1)'(SCREEN_MAX_X));
    end else begin
      moved_x_c    = {1'b0, shell_pos.x} - (COORD_W+1)'(SHELL_SPEED);
      spawn_x_c    = own_tank.x - COORD_W'(TANK_HALF);
      off_screen_c = (shell_pos.x < COORD_W'(SHELL_SPEED));
    end
    // An underflowed moved_x_c sits far above any tank, so it can never strike.
    strike_c = (abs_diff(moved_x_c, {1'b0, opp_tank.x}) <= HIT_RANGE) &&
               (abs_diff({1'b0, shell_pos.y}, {1'b0, opp_tank.y}) <= HIT_RANGE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cool_cnt  <= '0;
      armed     <= 1'b1;
      shell_pos <= '0;
      active    <= 1'b0;
      hit       <= 1'b0;
      score     <= '0;
    end else begin
      hit <= 1'b0;
      if (frame_tick) begin
        // A release seen on any frame re-arms; holding the key yields one shot.
        if (!fire_key_c) armed <= 1'b1;
        case (state)
          IDLE: begin
            if (fire_key_c && armed) begin
              state     <= FLYING;
              shell_pos <= '{x: spawn_x_c, y: own_tank.y};
              active    <= 1'b1;
              armed     <= 1'b0;
            end
          end
          FLYING: begin
            if (strike_c) begin
              shell_pos.x <= moved_x_c[COORD_W-1:0];
              hit         <= 1'b1;
              if (score != SCORE_W'(SCORE_MAX)) score <= score + SCORE_W'(1);
              active      <= 1'b0;
              cool_cnt    <= CNT_W'(COOLDOWN_FRAMES - 1);
              state       <= COOLDOWN;
            end else if (off_screen_c) begin
              active      <= 1'b0;
              cool_cnt    <= CNT_W'(COOLDOWN_FRAMES - 1);
              state       <= COOLDOWN;
            end else begin
              shell_pos.x <= moved_x_c[COORD_W-1:0];
            end
          end
          COOLDOWN: begin
            if (cool_cnt == '0) state <= IDLE;
            else                cool_cnt <= cool_cnt - CNT_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/shell_engine.sv
// Shell engine top: vsync rising-edge frame strobe plus the two player shell units.
module shell_engine
  import shell_engine_pkg::*;
(
  input  logic           Clk,
  input  logic           Reset_n,
  shell_engine_if.slave  bus
);

  logic   vs_q;
  logic   vs_qq;
  logic   frame_tick;
  point_t tank_one;
  point_t tank_two;
  point_t shell_one;
  point_t shell_two;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
    end else begin
      vs_q  <= bus.VS;
      vs_qq <= vs_q;
    end
  end

  assign frame_tick = vs_q & ~vs_qq;

  assign tank_one = '{x: bus.TankOneX, y: bus.TankOneY};
  assign tank_two = '{x: bus.TankTwoX, y: bus.TankTwoY};

  shell_unit #(.DIR(1), .FIRE_KEY(KEY_FIRE_ONE)) u_shell_one (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .frame_tick (frame_tick),
    .keycode    (bus.keycode),
    .own_tank   (tank_one),
    .opp_tank   (tank_two),
    .shell_pos  (shell_one),
    .active     (bus.ShellOneActive),
    .hit        (bus.HitOne),
    .score      (bus.ScoreOne)
  );

  shell_unit #(.DIR(-1), .FIRE_KEY(KEY_FIRE_TWO)) u_shell_two (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .frame_tick (frame_tick),
    .keycode    (bus.keycode),
    .own_tank   (tank_two),
    .opp_tank   (tank_one),
    .shell_pos  (shell_two),
    .active     (bus.ShellTwoActive),
    .hit        (bus.HitTwo),
    .score      (bus.ScoreTwo)
  );

  assign bus.ShellOneX = shell_one.x;
  assign bus.ShellOneY = shell_one.y;
  assign bus.ShellTwoX = shell_two.x;
  assign bus.ShellTwoY = shell_two.y;

endmodule
